// File: rtl/pool_grad_router_if.sv
// Handshake bundle of the pool gradient router: forward samples in,
// pooled-output gradients in, routed pre-pool gradients out.
interface pool_grad_router_if #(
  parameter int data_width = 32
);
  logic                  fwd_valid;
  logic [data_width-1:0] fwd_data;
  logic                  fwd_ready;
  logic                  grad_valid;
  logic [data_width-1:0] grad_data;
  logic                  grad_ready;
  logic                  out_valid;
  logic [data_width-1:0] out_data;
  logic                  out_ready;
  logic                  out_last;
  logic [1:0]            phase;

  modport slave (
    input  fwd_valid, fwd_data, grad_valid, grad_data, out_ready,
    output fwd_ready, grad_ready, out_valid, out_data, out_last, phase
  );

  modport master (
    output fwd_valid, fwd_data, grad_valid, grad_data, out_ready,
    input  fwd_ready, grad_ready, out_valid, out_data, out_last, phase
  );
endinterface

// File: rtl/pool_grad_router.sv
// Max-pool backward router: records the argmax of every pool window during
// the forward frame, then scatters upstream gradients back onto those positions.
//
// state   | meaning
// CAPTURE | accept input_size^2 forward samples, track per-window max/offset
// LOAD    | accept out_size^2 pooled gradients
// EMIT    | stream input_size^2 routed gradients, zero off the argmax
module pool_grad_router #(
  parameter int input_size   = 13,
  parameter int pooling_size = 2,
  parameter int data_width   = 32
) (
  input logic               clk,
  input logic               rstb,
  pool_grad_router_if.slave bus
);
  localparam int P    = pooling_size;
  localparam int OUT  = input_size / P;
  localparam int SPAN = OUT * P;
  localparam int NW   = (OUT * OUT > 0) ? OUT * OUT : 1;
  localparam int OFFW = (P * P > 1) ? $clog2(P * P) : 1;
  localparam int CW   = (input_size > 1) ? $clog2(input_size) : 1;
  localparam int WIX  = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0]  LAST_RC = CW'(input_size - 1);
  localparam logic [WIX-1:0] LAST_G  = WIX'(NW - 1);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    LOAD    = 2'd1,
    EMIT    = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                row_q, row_d;
  logic [CW-1:0]                col_q, col_d;
  logic [WIX-1:0]               gidx_q, gidx_d;
  logic signed [data_width-1:0] max_q [NW];
  logic signed [data_width-1:0] max_d [NW];
  logic [OFFW-1:0]              off_q [NW];
  logic [OFFW-1:0]              off_d [NW];
  logic [data_width-1:0]        grad_q [NW];
  logic [data_width-1:0]        grad_d [NW];

  logic            is_cap, is_load, is_emit;
  logic            in_win, rc_last, step;
  logic [WIX-1:0]  widx;
  logic [OFFW-1:0] woff;

  // The unused encoding 3 behaves exactly like CAPTURE.
  assign is_load = (state_q == LOAD);
  assign is_emit = (state_q == EMIT);
  assign is_cap  = !is_load && !is_emit;

  // Row/col counters are shared by CAPTURE and EMIT: both walk raster order.
  assign in_win  = (int'(row_q) < SPAN) && (int'(col_q) < SPAN);
  assign widx    = in_win ? WIX'((int'(row_q) / P) * OUT + int'(col_q) / P) : '0;
  assign woff    = OFFW'((int'(row_q) % P) * P + int'(col_q) % P);
  assign rc_last = (row_q == LAST_RC) && (col_q == LAST_RC);

  assign bus.fwd_ready  = is_cap;
  assign bus.grad_ready = is_load;
  assign bus.out_valid  = is_emit;
  assign bus.out_last   = is_emit && rc_last;
  assign bus.phase      = is_load ? 2'd1 : (is_emit ? 2'd2 : 2'd0);
  assign bus.out_data   = (is_emit && in_win && (off_q[widx] == woff)) ? grad_q[widx] : '0;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    gidx_d  = gidx_q;
    max_d   = max_q;
    off_d   = off_q;
    grad_d  = grad_q;
    step    = 1'b0;

    if (is_cap) begin
      state_d = CAPTURE;
      if (bus.fwd_valid) begin
        // Offset 0 is always the first sample of a window in raster order;
        // strict compare keeps the earliest sample on ties.
        if (in_win && ((woff == '0) || ($signed(bus.fwd_data) > max_q[widx]))) begin
          max_d[widx] = bus.fwd_data;
          off_d[widx] = woff;
        end
        step = 1'b1;
        if (rc_last) state_d = LOAD;
      end
    end else if (is_load) begin
      if (bus.grad_valid) begin
        grad_d[gidx_q] = bus.grad_data;
        if (gidx_q == LAST_G) begin
          gidx_d  = '0;
          state_d = EMIT;
        end else begin
          gidx_d = gidx_q + WIX'(1);
        end
      end
    end else if (bus.out_ready) begin
      step = 1'b1;
      if (rc_last) state_d = CAPTURE;
    end

    if (step) begin
      if (col_q == LAST_RC) begin
        col_d = '0;
        row_d = rc_last ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= CAPTURE;
      row_q   <= '0;
      col_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      gidx_q  <= gidx_d;
    end
  end

  // Buffers need no reset: every frame rewrites each entry before it is read.
  always_ff @(posedge clk) begin
    max_q  <= max_d;
    off_q  <= off_d;
    grad_q <= grad_d;
  end
endmodule

// File: tb/tb_pool_grad_router.sv
// Directed scoreboard bench for pool_grad_router at input_size 4 and 5, P=2.
module tb_pool_grad_router;
  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        sel = 1'b0;
  logic        fwd_valid = 1'b0;
  logic        grad_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] fwd_data = '0;
  logic [31:0] grad_data = '0;
  wire         fwd_ready, grad_ready, out_valid, out_last;
  wire  [31:0] out_data;
  wire  [1:0]  phase;

  int checks = 0;
  int passes = 0;
  int fwd_arr [25];
  int grad_arr [4];
  logic [31:0] exp_data_q [$];
  logic        exp_last_q [$];

  pool_grad_router_if #(.data_width(32)) if4 ();
  pool_grad_router_if #(.data_width(32)) if5 ();

  pool_grad_router #(.input_size(4), .pooling_size(2), .data_width(32)) u4 (
    .clk(clk), .rstb(rstb), .bus(if4));
  pool_grad_router #(.input_size(5), .pooling_size(2), .data_width(32)) u5 (
    .clk(clk), .rstb(rstb), .bus(if5));

  assign if4.fwd_valid  = fwd_valid & ~sel;
  assign if4.fwd_data   = fwd_data;
  assign if4.grad_valid = grad_valid & ~sel;
  assign if4.grad_data  = grad_data;
  assign if4.out_ready  = out_ready & ~sel;
  assign if5.fwd_valid  = fwd_valid & sel;
  assign if5.fwd_data   = fwd_data;
  assign if5.grad_valid = grad_valid & sel;
  assign if5.grad_data  = grad_data;
  assign if5.out_ready  = out_ready & sel;

  assign fwd_ready  = sel ? if5.fwd_ready  : if4.fwd_ready;
  assign grad_ready = sel ? if5.grad_ready : if4.grad_ready;
  assign out_valid  = sel ? if5.out_valid  : if4.out_valid;
  assign out_last   = sel ? if5.out_last   : if4.out_last;
  assign out_data   = sel ? if5.out_data   : if4.out_data;
  assign phase      = sel ? if5.phase      : if4.phase;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_fwd_ready"}, 32'(fwd_ready), 32'd1);
    check({tag, "_grad_ready"}, 32'(grad_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
  endtask

  // Reference: scan each 2x2 window, earliest strict max wins, scatter grad there.
  task automatic model_push(input int n);
    int o;
    int e [25];
    int best, boff, v;
    o = n / 2;
    for (int i = 0; i < 25; i++) e[i] = 0;
    for (int wr = 0; wr < o; wr++) begin
      for (int wc = 0; wc < o; wc++) begin
        best = 0;
        boff = 0;
        for (int d = 0; d < 4; d++) begin
          v = fwd_arr[(2 * wr + d / 2) * n + 2 * wc + d % 2];
          if (d == 0 || v > best) begin
            best = v;
            boff = d;
          end
        end
        e[(2 * wr + boff / 2) * n + 2 * wc + boff % 2] = grad_arr[wr * o + wc];
      end
    end
    for (int i = 0; i < n * n; i++) begin
      exp_data_q.push_back(32'(e[i]));
      exp_last_q.push_back(i == n * n - 1);
    end
  endtask

  task automatic send_fwd(input int n, input bit gaps);
    int t;
    for (int k = 0; k < n * n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      fwd_data  = 32'(fwd_arr[k]);
      fwd_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!fwd_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) check("fwd_ready_timeout", 32'(fwd_ready), 32'd1);
      @(posedge clk); #1;
      fwd_valid = 1'b0;
    end
    check("phase_load", 32'(phase), 32'd1);
  endtask

  task automatic send_grad(input int n, input bit gaps);
    int t;
    int o;
    o = n / 2;
    for (int g = 0; g < o * o; g++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      grad_data  = 32'(grad_arr[g]);
      grad_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!grad_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) check("grad_ready_timeout", 32'(grad_ready), 32'd1);
      @(posedge clk); #1;
      grad_valid = 1'b0;
    end
    check("emit_first_valid", 32'(out_valid), 32'd1);
    check("emit_phase", 32'(phase), 32'd2);
    check("grad_ready_after_last", 32'(grad_ready), 32'd0);
  endtask

  task automatic collect(input int n, input int stall_at, input int abort_at);
    int t;
    logic [31:0] hd;
    logic hl;
    logic [31:0] ed;
    logic el;
    out_ready = 1'b1;
    for (int e = 0; e < n * n; e++) begin
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) check("out_valid_timeout", 32'(out_valid), 32'd1);
      if (e == abort_at) begin
        out_ready = 1'b0;
        rstb = 1'b0;
        #1;
        check_idle("abort_async");
        @(posedge clk); #1;
        check("abort_next_phase", 32'(phase), 32'd0);
        check("abort_next_valid", 32'(out_valid), 32'd0);
        rstb = 1'b1;
        exp_data_q.delete();
        exp_last_q.delete();
        return;
      end
      if (e == stall_at) begin
        out_ready = 1'b0;
        hd = out_data;
        hl = out_last;
        repeat (3) begin
          @(negedge clk);
          check("stall_data", out_data, hd);
          check("stall_last", 32'(out_last), 32'(hl));
          check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
      end
      ed = exp_data_q.pop_front();
      el = exp_last_q.pop_front();
      check($sformatf("out_data[%0d]", e), out_data, ed);
      check($sformatf("out_last[%0d]", e), 32'(out_last), 32'(el));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("back_to_capture", 32'(phase), 32'd0);
    check("fwd_ready_after_frame", 32'(fwd_ready), 32'd1);
  endtask

  task automatic frame(input bit s, input int n, input bit gaps, input int stall_at,
                       input int abort_at);
    sel = s;
    model_push(n);
    send_fwd(n, gaps);
    send_grad(n, gaps);
    collect(n, stall_at, abort_at);
  endtask

  task automatic rand_frame(input int lo_span);
    for (int i = 0; i < 25; i++) fwd_arr[i] = int'($urandom_range(0, lo_span)) - lo_span / 2;
    for (int i = 0; i < 4; i++) grad_arr[i] = int'($urandom_range(1, 1000));
  endtask

  initial begin
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset4");
    sel = 1'b1;
    #1;
    check_idle("reset5");
    sel = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk); #1;

    // Gradients and output acceptance while in CAPTURE must be ignored.
    grad_valid = 1'b1;
    grad_data  = 32'd99;
    out_ready  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    grad_valid = 1'b0;
    out_ready  = 1'b0;
    check("ignore_grad_phase", 32'(phase), 32'd0);

    for (int i = 0; i < 16; i++) fwd_arr[i] = i;
    grad_arr = '{10, 20, 30, 40};
    frame(1'b0, 4, 1'b0, -1, -1);

    for (int i = 0; i < 16; i++) fwd_arr[i] = 5;
    grad_arr = '{1, 2, 3, 4};
    frame(1'b0, 4, 1'b0, -1, -1);

    rand_frame(16);
    fwd_arr[0] = -3; fwd_arr[1] = -1; fwd_arr[4] = -7; fwd_arr[5] = -2;
    grad_arr[0] = 9;
    frame(1'b0, 4, 1'b0, -1, -1);

    rand_frame(8);
    frame(1'b0, 4, 1'b1, 5, -1);
    frame(1'b0, 4, 1'b0, -1, -1);

    rand_frame(8);
    frame(1'b1, 5, 1'b1, 10, -1);

    rand_frame(4);
    frame(1'b0, 4, 1'b0, -1, 7);
    rand_frame(4);
    frame(1'b0, 4, 1'b1, -1, -1);

    rand_frame(2);
    frame(1'b1, 5, 1'b0, 24, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed time %0t limit 500000", $time);
    $fatal(1, "timeout");
  end
endmodule
